mult_arbiter: RTL and testbench

Shares one unsigned `WIDTH`×`WIDTH` multiplier between `NREQ` requesters. Arbitration is round-robin, with a valid/ready handshake on each request port. The block latches the winner's operands and computes the full-width product. It returns the product on a single response channel, tagged with the requester index. It sits between the processing lanes and the single multiplier instance, so the lanes never drive the multiplier directly.

---
 rtl/mult_arb_pkg.sv | 35 +++
 rtl/multiplier.sv | 14 +
 rtl/mult_arbiter.sv | 102 ++++++++++
 tb/tb_mult_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// Shared types and the round-robin pick helper for mult_arbiter.
// Pure declarations, no latency.
// No flow control of its own.
package mult_arb_pkg;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    // Upper bounds the helper is sized for; callers zero-extend into them.
    localparam int RR_MAX  = 32;
    localparam int RR_ID_W = 5;

    typedef struct packed {
        logic               found;
        logic [RR_ID_W-1:0] idx;
    } rr_pick_t;

    // Search last+1, last+2, ... modulo nreq; first set valid bit wins.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0]  valid,
                                         input logic [RR_ID_W-1:0] last,
                                         input int                 nreq);
        rr_pick_t r;
        int       cand;
        r = '0;
        for (int k = 1; k <= RR_MAX; k++) begin
            cand = int'(last) + k;
            if (cand >= nreq) cand = cand - nreq;
            if (k <= nreq && !r.found && valid[cand[RR_ID_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = cand[RR_ID_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/multiplier.sv
// Unsigned full-width combinational multiplier.
// Latency 0; the caller registers the result.
// No flow control.
module multiplier #(
    parameter int parallelism = 8
) (
    input  logic [parallelism-1:0]   a,
    input  logic [parallelism-1:0]   b,
    output logic [2*parallelism-1:0] product
);

    assign product = (2*parallelism)'(a) * (2*parallelism)'(b);

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin shares one multiplier between NREQ requesters, tagged response.
// Latency: accept in cycle N -> resp_valid in cycle N+2; one op per 2 cycles.
// Backpressure: resp_ready low holds the response and deasserts all req_ready.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 8,
    localparam int ID_W  = $clog2(NREQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ-1:0][WIDTH-1:0]  req_a,
    input  logic [NREQ-1:0][WIDTH-1:0]  req_b,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [ID_W-1:0]             resp_id,
    output logic [2*WIDTH-1:0]          resp_product,
    output logic                        busy
);

    state_t             state_q, state_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] mult_product;

    rr_pick_t           pick;
    logic [ID_W-1:0]    win_id;
    logic               can_accept;
    logic               grant;

    multiplier #(.parallelism(WIDTH)) u_mult (
        .a       (a_q),
        .b       (b_q),
        .product (mult_product)
    );

    assign pick       = rr_pick(RR_MAX'(req_valid), RR_ID_W'(last_q), NREQ);
    assign win_id     = pick.idx[ID_W-1:0];
    // A finishing response frees the multiplier in the same cycle it is taken.
    assign can_accept = (state_q == IDLE) || (state_q == RESP && resp_ready);
    assign grant      = can_accept && pick.found;

    always_comb begin
        req_ready = '0;
        if (grant) req_ready[win_id] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;

        if (grant) begin
            last_d = win_id;
            id_d   = win_id;
            a_d    = req_a[win_id];
            b_d    = req_b[win_id];
        end

        unique case (state_q)
            IDLE: if (grant) state_d = EXEC;
            EXEC: begin
                prod_d  = mult_product;
                state_d = RESP;
            end
            RESP: if (resp_ready) state_d = grant ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= ID_W'(NREQ - 1);
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
        end
    end

    assign resp_valid   = (state_q == RESP);
    assign resp_id      = id_q;
    assign resp_product = prod_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with immediate-assertion checks.
module tb_mult_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                       clk;
    logic                       rst;
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ-1:0][WIDTH-1:0] req_a;
    logic [NREQ-1:0][WIDTH-1:0] req_b;
    logic                       resp_valid;
    logic                       resp_ready;
    logic [1:0]                 resp_id;
    logic [2*WIDTH-1:0]         resp_product;
    logic                       busy;

    int checks = 0;
    int errors = 0;

    mult_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_product (resp_product),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single isolated op: present, check grant, wait two cycles, check response, drain.
    task automatic do_op(input string tag, input int idx, input int a, input int b,
                         input int exp_prod);
        req_valid      = 4'(1 << idx);
        req_a[idx]     = 8'(a);
        req_b[idx]     = 8'(b);
        resp_ready     = 1'b1;
        #1;
        chk({tag, "_ready"}, 32'(req_ready), 32'(1 << idx));
        step();
        req_valid = '0;
        step();
        chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, "_id"}, 32'(resp_id), 32'(idx));
        chk({tag, "_prod"}, 32'(resp_product), 32'(exp_prod));
        step();
    endtask

    int order[6]    = '{0, 1, 2, 3, 0, 1};
    int all_prod[4] = '{30, 100, 210, 360};

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        step();
        step();
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_id", 32'(resp_id), 32'd0);
        chk("rst_resp_product", 32'(resp_product), 32'd0);
        rst = 1'b0;
        step();

        // Single request: 200*255, latency N -> N+2.
        req_valid  = 4'b0001;
        req_a[0]   = 8'd200;
        req_b[0]   = 8'd255;
        resp_ready = 1'b1;
        #1;
        chk("single_ready", 32'(req_ready), 32'b0001);
        step();
        req_valid = '0;
        #1;
        chk("single_exec_valid", 32'(resp_valid), 32'd0);
        chk("single_exec_busy", 32'(busy), 32'd1);
        step();
        chk("single_valid", 32'(resp_valid), 32'd1);
        chk("single_id", 32'(resp_id), 32'd0);
        chk("single_prod", 32'(resp_product), 32'd51000);
        step();
        chk("single_idle_valid", 32'(resp_valid), 32'd0);
        chk("single_idle_busy", 32'(busy), 32'd0);

        // All requesters from a fresh reset: grants 0,1,2,3,0,1 every 2 cycles.
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_a      = {8'd40, 8'd30, 8'd20, 8'd10};
        req_b      = {8'd9, 8'd7, 8'd5, 8'd3};
        req_valid  = 4'b1111;
        resp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("all_ready", 32'(req_ready), 32'(1 << order[k]));
            if (k > 0) begin
                chk("all_resp_valid", 32'(resp_valid), 32'd1);
                chk("all_resp_id", 32'(resp_id), 32'(order[k-1]));
                chk("all_resp_prod", 32'(resp_product), 32'(all_prod[order[k-1]]));
            end
            step();
            chk("all_exec_valid", 32'(resp_valid), 32'd0);
            chk("all_exec_ready", 32'(req_ready), 32'd0);
            step();
        end
        chk("all_last_id", 32'(resp_id), 32'd1);
        chk("all_last_prod", 32'(resp_product), 32'd100);
        req_valid = '0;
        step();

        // Skip idle requester: last grant was 1, only 3 requests.
        do_op("skip_3", 3, 255, 255, 65025);
        do_op("zero", 0, 0, 173, 0);
        do_op("one", 1, 1, 255, 255);

        // Backpressure: response held for 5 cycles, request 2 waiting.
        req_valid  = 4'b0001;
        req_a[0]   = 8'd100;
        req_b[0]   = 8'd50;
        resp_ready = 1'b0;
        #1;
        chk("bp_accept", 32'(req_ready), 32'b0001);
        step();
        req_valid = 4'b0100;
        req_a[2]  = 8'd12;
        req_b[2]  = 8'd12;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", 32'(resp_valid), 32'd1);
            chk("bp_hold_id", 32'(resp_id), 32'd0);
            chk("bp_hold_prod", 32'(resp_product), 32'd5000);
            chk("bp_hold_ready", 32'(req_ready), 32'd0);
            step();
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'b0100);
        chk("bp_release_valid", 32'(resp_valid), 32'd1);
        step();
        req_valid = '0;
        chk("bp_exec_valid", 32'(resp_valid), 32'd0);
        step();
        chk("bp_r2_id", 32'(resp_id), 32'd2);
        chk("bp_r2_prod", 32'(resp_product), 32'd144);
        step();

        // Reset during EXEC drops the op; requester 0 has priority afterwards.
        req_valid = 4'b0010;
        req_a[1]  = 8'd99;
        req_b[1]  = 8'd99;
        #1;
        chk("rmid_accept", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        chk("rmid_in_exec", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rmid_async_busy", 32'(busy), 32'd0);
        chk("rmid_async_valid", 32'(resp_valid), 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rmid_no_resp", 32'(resp_valid), 32'd0);
            step();
        end
        req_valid = 4'b1001;
        req_a[0]  = 8'd7;
        req_b[0]  = 8'd9;
        req_a[3]  = 8'd2;
        req_b[3]  = 8'd3;
        #1;
        chk("rmid_first_grant", 32'(req_ready), 32'b0001);
        step();
        step();
        chk("rmid_r0_id", 32'(resp_id), 32'd0);
        chk("rmid_r0_prod", 32'(resp_product), 32'd63);
        chk("rmid_next_grant", 32'(req_ready), 32'b1000);
        step();
        req_valid = '0;
        step();
        chk("rmid_r3_id", 32'(resp_id), 32'd3);
        chk("rmid_r3_prod", 32'(resp_product), 32'd6);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
